// File: rtl/logic_gate_unit.sv
// ---------------------------------------------------------------------------
// logic_gate_unit
//   Registered WIDTH-bit bitwise gate with a runtime-selectable operation.
//   Single mode computes (a op b) from one beat. Accumulate mode folds a
//   multi-beat stream of words through the selected gate and reports the
//   folded word when the beat flagged 'last' arrives. Input and output use
//   valid/ready handshakes. One result is produced per transaction and held
//   until the consumer accepts it.
//
// Ports
//   clk       : rising-edge clock, the only clock
//   rst       : synchronous, active-high reset
//   in_valid  : input beat offered
//   in_ready  : unit can accept a beat (decoded from the state register)
//   a         : operand A / stream word
//   b         : operand B, used in single mode only
//   op        : 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR,
//               110 NOT a, 111 pass a (sampled on the first beat)
//   mode      : 0 single-shot, 1 accumulate (sampled on the first beat)
//   last      : final beat of an accumulate transaction
//   out_valid : result available
//   out_ready : consumer accepts result
//   y         : registered result
//   count     : beats consumed by the current result, saturating
// ---------------------------------------------------------------------------
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [LEN_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  // Binary gates combine lhs and rhs; the unary codes act on the incoming
  // word only, which is 'a' in both modes.
  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_lhs,
    input logic [WIDTH-1:0] f_rhs,
    input logic [WIDTH-1:0] f_word
  );
    logic [WIDTH-1:0] f_res;
    case (f_op)
      3'b000:  f_res = f_lhs & f_rhs;
      3'b001:  f_res = f_lhs | f_rhs;
      3'b010:  f_res = ~(f_lhs & f_rhs);
      3'b011:  f_res = ~(f_lhs | f_rhs);
      3'b100:  f_res = f_lhs ^ f_rhs;
      3'b101:  f_res = ~(f_lhs ^ f_rhs);
      3'b110:  f_res = ~f_word;
      3'b111:  f_res = f_word;
      default: f_res = {WIDTH{1'b0}};
    endcase
    return f_res;
  endfunction

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_mode;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic [LEN_W-1:0] r_count;

  state_t           w_next_state;
  logic [2:0]       w_next_op;
  logic             w_next_mode;
  logic [WIDTH-1:0] w_next_acc;
  logic [WIDTH-1:0] w_next_y;
  logic [LEN_W-1:0] w_next_count;

  logic             w_beat;
  logic             w_result_accept;
  logic [WIDTH-1:0] w_acc_gate;
  logic [LEN_W-1:0] w_count_inc;

  // Handshake flags are decoded from the state register only, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign y         = r_y;
  assign count     = r_count;

  assign w_beat          = in_valid && in_ready;
  assign w_result_accept = out_valid && out_ready;
  assign w_acc_gate      = gate_f(r_op, r_acc, a, a);
  assign w_count_inc     = (r_count == CNT_MAX) ? r_count : (r_count + CNT_ONE);

  // Next-state and next-datapath decode for the IDLE/ACC/HOLD controller.
  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op;
    w_next_mode  = r_mode;
    w_next_acc   = r_acc;
    w_next_y     = r_y;
    w_next_count = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          w_next_op    = op;
          w_next_mode  = mode;
          w_next_count = CNT_ONE;
          if (!mode) begin
            w_next_y     = gate_f(op, a, b, a);
            w_next_state = S_HOLD;
          end else begin
            w_next_acc = a;
            if (last) begin
              w_next_y     = a;
              w_next_state = S_HOLD;
            end else begin
              w_next_state = S_ACC;
            end
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACC: begin
        // op/mode/b are ignored here; the latched op drives the fold.
        if (w_beat) begin
          w_next_acc   = w_acc_gate;
          w_next_count = w_count_inc;
          if (last) begin
            w_next_y     = w_acc_gate;
            w_next_state = S_HOLD;
          end else begin
            w_next_state = S_ACC;
          end
        end else begin
          w_next_state = S_ACC;
        end
      end
      S_HOLD: begin
        if (w_result_accept) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_HOLD;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'b000;
      r_mode  <= 1'b0;
      r_acc   <= {WIDTH{1'b0}};
      r_y     <= {WIDTH{1'b0}};
      r_count <= {LEN_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_op    <= w_next_op;
      r_mode  <= w_next_mode;
      r_acc   <= w_next_acc;
      r_y     <= w_next_y;
      r_count <= w_next_count;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       mode;
  logic       last;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] y;
  logic [3:0] count;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] y2;
  logic [1:0] count2;

  int checks;
  int failures;

  logic_gate_unit #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .count(count)
  );

  // Narrow-counter instance driven in lockstep, used for saturation.
  logic_gate_unit #(.WIDTH(8), .LEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .mode(mode), .last(last),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [7:0] va, input logic [7:0] vb,
                          input logic [2:0] vop, input logic vmode,
                          input logic vlast);
    in_valid = 1'b1;
    a = va; b = vb; op = vop; mode = vmode; last = vlast;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || y !== 8'h00 || count !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: out_valid=%b y=%h count=%0d in_ready=%b, want 0 00 0 1",
               out_valid, y, count, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_nor();
    out_ready = 1'b1;
    set_beat(8'hA5, 8'h0F, 3'b011, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h50 || count !== 4'd1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_nor: out_valid=%b y=%h count=%0d in_ready=%b, want 1 50 1 0",
               out_valid, y, count, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_nor_release: out_valid=%b in_ready=%b, want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_acc_and();
    out_ready = 1'b1;
    set_beat(8'hF0, 8'h00, 3'b000, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 4'd1) begin
      failures++;
      $display("FAIL acc_and_b1: in_ready=%b out_valid=%b count=%0d, want 1 0 1",
               in_ready, out_valid, count);
    end
    set_beat(8'h3C, 8'h00, 3'b000, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_and_b2: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    set_beat(8'hFF, 8'h00, 3'b000, 1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h30 || count !== 4'd3) begin
      failures++;
      $display("FAIL acc_and: out_valid=%b y=%h count=%0d, want 1 30 3", out_valid, y, count);
    end
    tick();
  endtask

  task automatic test_acc_nor();
    out_ready = 1'b1;
    set_beat(8'h0F, 8'h00, 3'b011, 1'b1, 1'b0);
    tick();
    // op changed on later beats must be ignored
    set_beat(8'hF0, 8'hAA, 3'b000, 1'b0, 1'b0);
    tick();
    set_beat(8'h01, 8'hAA, 3'b000, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'hFE || count !== 4'd3) begin
      failures++;
      $display("FAIL acc_nor: out_valid=%b y=%h count=%0d, want 1 FE 3", out_valid, y, count);
    end
    tick();
  endtask

  task automatic test_acc_not();
    out_ready = 1'b1;
    set_beat(8'h12, 8'h00, 3'b110, 1'b1, 1'b0);
    tick();
    set_beat(8'h34, 8'h00, 3'b001, 1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'hCB || count !== 4'd2) begin
      failures++;
      $display("FAIL acc_not: out_valid=%b y=%h count=%0d, want 1 CB 2", out_valid, y, count);
    end
    tick();
  endtask

  task automatic test_acc_single_beat();
    out_ready = 1'b1;
    set_beat(8'h5A, 8'hFF, 3'b000, 1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h5A || count !== 4'd1) begin
      failures++;
      $display("FAIL acc_one_beat: out_valid=%b y=%h count=%0d, want 1 5A 1", out_valid, y, count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(8'hFF, 8'h0F, 3'b100, 1'b0, 1'b0);
    tick();
    // second beat held by the producer while the result is stalled
    set_beat(8'h11, 8'h22, 3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || y !== 8'hF0 || in_ready !== 1'b0 || count !== 4'd1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b y=%h in_ready=%b count=%0d, want 1 F0 0 1",
                 i, out_valid, y, in_ready, count);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'hF0) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b y=%h, want 0 1 F0",
               out_valid, in_ready, y);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h33 || count !== 4'd1) begin
      failures++;
      $display("FAIL back_to_back: out_valid=%b y=%h count=%0d, want 1 33 1", out_valid, y, count);
    end
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(8'h01, 8'h00, 3'b100, 1'b1, (i == 5) ? 1'b1 : 1'b0);
      tick();
      if (i == 3) begin
        checks++;
        if (count2 !== 2'd3 || count !== 4'd4) begin
          failures++;
          $display("FAIL sat_mid: count2=%0d count=%0d, want 3 4", count2, count);
        end
      end
    end
    idle_inputs();
    checks++;
    if (out_valid2 !== 1'b1 || y2 !== 8'h00 || count2 !== 2'd3) begin
      failures++;
      $display("FAIL saturation: out_valid=%b y=%h count=%0d, want 1 00 3", out_valid2, y2, count2);
    end
    checks++;
    if (y !== 8'h00 || count !== 4'd6) begin
      failures++;
      $display("FAIL sat_wide: y=%h count=%0d, want 00 6", y, count);
    end
    tick();
  endtask

  task automatic test_reset_mid_acc();
    out_ready = 1'b1;
    set_beat(8'h77, 8'h00, 3'b001, 1'b1, 1'b0);
    tick();
    set_beat(8'h88, 8'h00, 3'b001, 1'b1, 1'b0);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || y !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_acc: out_valid=%b count=%0d y=%h in_ready=%b, want 0 0 00 1",
               out_valid, count, y, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_output: out_valid=%b, want 0", out_valid);
    end
    set_beat(8'h11, 8'h22, 3'b001, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h33 || count !== 4'd1) begin
      failures++;
      $display("FAIL reset_then_or: out_valid=%b y=%h count=%0d, want 1 33 1", out_valid, y, count);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00; op = 3'b000; mode = 1'b0; last = 1'b0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single_nor();
    test_acc_and();
    test_acc_nor();
    test_acc_not();
    test_acc_single_beat();
    test_backpressure();
    test_saturation();
    test_reset_mid_acc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
